rca4_seq_adder_ctrl: RTL and testbench
======================================

Name: rca4_seq_adder_ctrl

Overview:
- Sequencing controller that adds two wide operands by time-sharing one RCA4 4-bit ripple-carry adder, one nibble per clock.
- Latches the operands on a start request, walks the nibbles from LSB to MSB, and registers the carry between steps.
- Assembles the result, then signals completion with a done pulse.
- Used in the board demos to extend the 4-bit adder to 16-bit and wider additions without replicating adder hardware.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..8.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition. Sampled only in IDLE.
- A  input  W  operand A. Latched on an accepted start.
- B  input  W  operand B. Latched on an accepted start.
- Cin  input  1  carry-in for nibble 0. Latched on an accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when S, Cout and ovfl become valid.
- S  output  W  registered sum. Held until the next completion.
- Cout  output  1  carry out of the MSB nibble.
- ovfl  output  1  two's-complement overflow of the W-bit add.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, S=0, Cout=0, ovfl=0.
  - Internal operand regs, carry reg and nibble counter cleared.
- Exactly one RCA4 instance. Its A/B/Cin are driven from the current nibble of the latched operands and the carry reg.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0.
  - If start=1 at a clock edge: latch A, B, Cin into operand regs and carry reg; set cnt=0; go to ADD.
  - Otherwise remain in IDLE.
- ADD:
  - busy=1.
  - Each edge writes RCA4 sum into S[4*cnt+3:4*cnt] and RCA4 Cout into the carry reg, then increments cnt.
  - When cnt==NIBBLES-1 at the edge, also load Cout from the RCA4 carry out and compute ovfl, then go to DONE.
  - ovfl = (A[W-1]==B[W-1]) && (sum MSB != A[W-1]), using the latched A and B.
  - start is ignored in ADD. The latched operands are not disturbed.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - start=1 in the DONE cycle is accepted as a new request: operands latch and the next state is ADD (back-to-back operation).
- Latency: start sampled at edge E0 → busy=1 after E0 → done=1 in the cycle after edge E(NIBBLES). This gives NIBBLES+1 edges from acceptance to done.
- S nibble update order:
  - S is updated nibble by nibble during ADD. Intermediate S values are not guaranteed meaningful.
  - S/Cout/ovfl are architecturally valid from the done cycle until the next done.
- Widths:
  - All sums are mod 2^W.
  - Cout is the true carry out of bit W-1.
  - Carry propagates only through the carry reg, never combinationally across nibbles.
- Boundary conditions:
  - Reset asserted mid-ADD: immediate abort to IDLE with all outputs zero. No done pulse.
  - start held high continuously: a new add begins every NIBBLES+1 cycles.
  - start and reset release in the same cycle: start is ignored until the first edge with rst_n=1.
  - Operand inputs changing during ADD have no effect on the result.

Test Plan:
- Reset, then A=0x1234, B=0x0FFF, Cin=0, start one cycle → busy for 4 cycles, done pulse on cycle 5; S=0x2233, Cout=0, ovfl=0.
- A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, ovfl=0. Checks carry rippling through all four nibble steps.
- A=0x7FFF, B=0x0001 → S=0x8000, Cout=0, ovfl=1. Then A=0x8000, B=0x8000 → S=0x0000, Cout=1, ovfl=1.
- A=0x0000, B=0x0000, Cin=1 → S=0x0001, Cout=0. Then start pulsed again mid-ADD with different operands → ignored; result unchanged; exactly one done pulse.
- Start 0x1111+0x2222 with start also high in the done cycle, carrying new operands 0x0F0F+0x00F1 → first done gives S=0x3333, second done 5 cycles later gives S=0x1000, and busy stays low for only the single DONE cycle between the two adds.
- Start an add, drop rst_n after 2 ADD cycles → busy, done, S, Cout, ovfl all 0 immediately. After release, no done appears until a new start is given.

Source files
------------

// File: rtl/rca4_seq_adder_ctrl.sv
// Wide adder built by stepping a single 4-bit ripple-carry adder across the operand nibbles,
// LSB first, with the inter-nibble carry held in a register.

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic c1, c2, c3;

    assign s[0] = a[0] ^ b[0] ^ cin;
    assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign c2   = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
    assign s[2] = a[2] ^ b[2] ^ c2;
    assign c3   = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);
    assign s[3] = a[3] ^ b[3] ^ c3;
    assign cout = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched when it arrives
// ADD   | one nibble summed per clock, carry kept in carry_q
// DONE  | result valid, done pulse; start here chains the next add
module rca4_seq_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 ovfl
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [CW-1:0] cnt;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    rca_s;
    logic          rca_cout;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    rca4 u_rca4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (rca_s),
        .cout (rca_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            ovfl    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CW'(i)) S[4*i +: 4] <= rca_s;
                    end
                    carry_q <= rca_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Cout  <= rca_cout;
                        // Signed overflow: like-signed operands giving an opposite-signed sum
                        ovfl  <= (a_q[W-1] == b_q[W-1]) && (rca_s[3] != a_q[W-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca4_seq_adder_ctrl.sv
// Directed bench for the nibble-serial adder: latency, carry/overflow corners, chaining and reset abort.

module tb_rca4_seq_adder_ctrl;
    logic        clk_sys;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [15:0] S;
    logic        Cout;
    logic        ovfl;

    int n_tests = 0;
    int n_fail  = 0;

    rca4_seq_adder_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovfl  (ovfl)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; walks negedges until done, returns negedges taken and busy count.
    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            @(negedge clk_sys);
            n++;
        end
    endtask

    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] es, input logic ec, input logic ev);
        int n, nb;
        @(negedge clk_sys);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(n, nb);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_nbusy"}, nb, 4);
        chk({tag, "_S"}, S, es);
        chk({tag, "_Cout"}, Cout, ec);
        chk({tag, "_ovfl"}, ovfl, ev);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int n, nb, ndone;
        rst_n = 1'b0; start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_S", S, 0);
        chk("rst_CoutOvfl", {Cout, ovfl}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_sys);
        chk("idle_busy", busy, 0);

        run_add("t1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_add("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_add("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_add("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start and operand changes during ADD must be ignored
        @(negedge clk_sys);
        A = 16'h0000; B = 16'h0000; Cin = 1'b1; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        @(negedge clk_sys);
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b0; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk("t4_busy_mid", busy, 1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t4_lat", n, 2);
        chk("t4_S", S, 16'h0001);
        chk("t4_Cout", Cout, 0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (done) ndone++;
        end
        chk("t4_extra_done", ndone, 0);

        // back-to-back via start in the DONE cycle
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        A = 16'h0F0F; B = 16'h00F1;
        wait_done(n, nb);
        chk("t5_lat1", n, 4);
        chk("t5_S1", S, 16'h3333);
        chk("t5_busy_gap", busy, 0);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk("t5_busy_again", busy, 1);
        chk("t5_done_low", done, 0);
        wait_done(n, nb);
        chk("t5_lat2", n, 4);
        chk("t5_S2", S, 16'h1000);
        chk("t5_Cout2", Cout, 0);

        // start held high: one add every NIBBLES+1 cycles
        @(negedge clk_sys);
        A = 16'h0001; B = 16'h0002; Cin = 1'b0; start = 1'b1;
        @(negedge clk_sys);
        wait_done(n, nb);
        @(negedge clk_sys);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t6_period", n, 5);
        chk("t6_S", S, 16'h0003);
        start = 1'b0;
        repeat (6) @(negedge clk_sys);

        // reset during ADD aborts immediately
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        @(negedge clk_sys);
        chk("t7_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_S", S, 0);
        chk("t7_CoutOvfl", {Cout, ovfl}, 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        ndone = 0;
        nb = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (done) ndone++;
            if (busy) nb++;
        end
        chk("t7_no_done", ndone, 0);
        chk("t7_no_busy", nb, 0);
        run_add("t8", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
